midi_voice_allocator: RTL and testbench

Consumes decoded MIDI channel events from the MIDI framer (command byte plus two 7-bit parameters with a valid/ack handshake) and turns them into per-voice note, velocity, gate and trigger controls for a bank of polyphonic synth voices. Sits directly downstream of the UART/MIDI framer and upstream of the voice oscillators/envelopes. Handles note-on/off, velocity-0 note-off, sustain pedal (CC64), all-notes-off (CC123), and oldest-voice stealing.

---
 rtl/midi_voice_allocator_pkg.sv | 63 ++++++
 rtl/midi_voice_allocator_if.sv | 25 ++
 rtl/midi_voice_allocator_voice_select.sv | 45 ++++
 rtl/midi_voice_allocator.sv | 180 ++++++++++++++++++
 tb/tb_midi_voice_allocator.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/midi_voice_allocator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : midi_voice_allocator_pkg
//  Description : Shared MIDI constants, FSM state and decoded-operation types
//                for the polyphonic voice allocator.
//  Revision    : 1.0  initial release
// ============================================================================
package midi_voice_allocator_pkg;

    // Command nibbles (upper half of the status byte)
    localparam logic [3:0] NOTE_OFF          = 4'h8;
    localparam logic [3:0] NOTE_ON           = 4'h9;
    localparam logic [3:0] CC                = 4'hB;

    // Controller numbers and thresholds
    localparam logic [6:0] CC_SUSTAIN        = 7'd64;
    localparam logic [6:0] CC_ALL_NOTES_OFF  = 7'd123;
    localparam logic [6:0] SUSTAIN_THRESHOLD = 7'd64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_APPLY  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE       = 3'd0,
        OP_NOTE_ON    = 3'd1,
        OP_NOTE_OFF   = 3'd2,
        OP_PEDAL_DOWN = 3'd3,
        OP_PEDAL_UP   = 3'd4,
        OP_ALL_OFF    = 3'd5
    } op_t;

    // Reduce a channel event to the single voice operation it implies.
    // Off-channel events and unsupported commands collapse to OP_NONE.
    function automatic op_t decode_op(
        input logic [7:0] cmd,
        input logic [6:0] p1,
        input logic [6:0] p2,
        input logic [3:0] channel,
        input logic       omni
    );
        op_t op;
        op = OP_NONE;
        if (omni || (cmd[3:0] == channel)) begin
            case (cmd[7:4])
                NOTE_ON:  op = (p2 != 7'd0) ? OP_NOTE_ON : OP_NOTE_OFF;
                NOTE_OFF: op = OP_NOTE_OFF;
                CC: begin
                    if (p1 == CC_SUSTAIN)
                        op = (p2 >= SUSTAIN_THRESHOLD) ? OP_PEDAL_DOWN : OP_PEDAL_UP;
                    else if (p1 == CC_ALL_NOTES_OFF)
                        op = OP_ALL_OFF;
                end
                default: op = OP_NONE;
            endcase
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/midi_voice_allocator_if.sv
`default_nettype none
// ============================================================================
//  Module      : midi_voice_allocator_if
//  Description : Decoded MIDI event bus between framer (master) and voice
//                allocator (slave), valid held until a one-cycle ack.
//  Revision    : 1.0  initial release
// ============================================================================
interface midi_voice_allocator_if;
    logic [7:0] midi_command;
    logic [6:0] midi_parameter_1;
    logic [6:0] midi_parameter_2;
    logic       midi_event_valid;
    logic       midi_event_ack;

    modport master (
        output midi_command, midi_parameter_1, midi_parameter_2, midi_event_valid,
        input  midi_event_ack
    );

    modport slave (
        input  midi_command, midi_parameter_1, midi_parameter_2, midi_event_valid,
        output midi_event_ack
    );
endinterface
`default_nettype wire

// File: rtl/midi_voice_allocator_voice_select.sv
`default_nettype none
// ============================================================================
//  Module      : voice_select
//  Description : Combinational voice search: gated voice already playing the
//                key, lowest-index free voice, and the oldest voice.
//  Revision    : 1.0  initial release
// ============================================================================
module voice_select #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 2
) (
    input  wire logic [NUM_VOICES-1:0]       gate,
    input  wire logic [7*NUM_VOICES-1:0]     note,
    input  wire logic [AGE_W*NUM_VOICES-1:0] age,
    input  wire logic [6:0]                  key,
    output logic                             match_valid,
    output logic [AGE_W-1:0]                 match_idx,
    output logic                             free_valid,
    output logic [AGE_W-1:0]                 free_idx,
    output logic [AGE_W-1:0]                 oldest_idx
);

    // Scan high to low so the lowest matching index wins
    always_comb begin
        match_valid = 1'b0;
        match_idx   = '0;
        free_valid  = 1'b0;
        free_idx    = '0;
        oldest_idx  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (gate[i] && (note[7*i +: 7] == key)) begin
                match_valid = 1'b1;
                match_idx   = AGE_W'(i);
            end
            if (!gate[i]) begin
                free_valid = 1'b1;
                free_idx   = AGE_W'(i);
            end
            if (age[AGE_W*i +: AGE_W] == AGE_W'(NUM_VOICES - 1))
                oldest_idx = AGE_W'(i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/midi_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : midi_voice_allocator
//  Description : Turns decoded MIDI channel events into per-voice note,
//                velocity, gate and trigger controls with sustain pedal,
//                all-notes-off and oldest-voice stealing.
//  Revision    : 1.0  initial release
// ============================================================================
module midi_voice_allocator
    import midi_voice_allocator_pkg::*;
#(
    parameter int         NUM_VOICES   = 4,
    parameter logic [3:0] MIDI_CHANNEL = 4'd0,
    parameter bit         OMNI         = 1'b0
) (
    input  wire logic                    clk,
    input  wire logic                    resetn,
    midi_voice_allocator_if.slave        evt,
    output logic [7*NUM_VOICES-1:0]      voice_note,
    output logic [7*NUM_VOICES-1:0]      voice_velocity,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NUM_VOICES-1:0]        voice_trigger
);

    localparam int AGE_W = $clog2(NUM_VOICES);

    state_t                              state_q, state_d;
    logic [7:0]                          cmd_q, cmd_d;
    logic [6:0]                          key_q, key_d;
    logic [6:0]                          val_q, val_d;
    op_t                                 op_q, op_d;
    logic [AGE_W-1:0]                    sel_q, sel_d;
    logic [NUM_VOICES-1:0][6:0]          note_q, note_d;
    logic [NUM_VOICES-1:0][6:0]          vel_q, vel_d;
    logic [NUM_VOICES-1:0]               gate_q, gate_d;
    logic [NUM_VOICES-1:0]               sus_q, sus_d;
    logic [NUM_VOICES-1:0][AGE_W-1:0]    age_q, age_d;
    logic [NUM_VOICES-1:0]               trig_q, trig_d;
    logic                                pedal_q, pedal_d;

    logic                                match_valid, free_valid;
    logic [AGE_W-1:0]                    match_idx, free_idx, oldest_idx;
    logic [AGE_W-1:0]                    old_age;

    voice_select #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W)
    ) u_voice_select (
        .gate        (gate_q),
        .note        (note_q),
        .age         (age_q),
        .key         (key_q),
        .match_valid (match_valid),
        .match_idx   (match_idx),
        .free_valid  (free_valid),
        .free_idx    (free_idx),
        .oldest_idx  (oldest_idx)
    );

    // Ack is a pure function of state so an async reset drops it at once
    assign evt.midi_event_ack = (state_q == ST_DECODE);
    assign voice_note         = note_q;
    assign voice_velocity     = vel_q;
    assign voice_gate         = gate_q;
    assign voice_trigger      = trig_q;

    // Next-state: capture, decode/select, then apply to the voice bank
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        key_d   = key_q;
        val_d   = val_q;
        op_d    = op_q;
        sel_d   = sel_q;
        note_d  = note_q;
        vel_d   = vel_q;
        gate_d  = gate_q;
        sus_d   = sus_q;
        age_d   = age_q;
        trig_d  = '0;
        pedal_d = pedal_q;
        old_age = age_q[sel_q];

        case (state_q)
            ST_IDLE: begin
                if (evt.midi_event_valid) begin
                    cmd_d   = evt.midi_command;
                    key_d   = evt.midi_parameter_1;
                    val_d   = evt.midi_parameter_2;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                op_d    = decode_op(cmd_q, key_q, val_q, MIDI_CHANNEL, OMNI);
                sel_d   = match_valid ? match_idx : (free_valid ? free_idx : oldest_idx);
                state_d = ST_APPLY;
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
                case (op_q)
                    OP_NOTE_ON: begin
                        // Chosen voice becomes youngest; voices younger than
                        // its old age shift up one, keeping a permutation
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (AGE_W'(i) == sel_q) begin
                                note_d[i] = key_q;
                                vel_d[i]  = val_q;
                                gate_d[i] = 1'b1;
                                sus_d[i]  = 1'b0;
                                trig_d[i] = 1'b1;
                                age_d[i]  = '0;
                            end else if (age_q[i] < old_age) begin
                                age_d[i]  = age_q[i] + AGE_W'(1);
                            end
                        end
                    end
                    OP_NOTE_OFF: begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (gate_q[i] && (note_q[i] == key_q) && !sus_q[i]) begin
                                if (pedal_q) sus_d[i]  = 1'b1;
                                else         gate_d[i] = 1'b0;
                            end
                        end
                    end
                    OP_PEDAL_DOWN: pedal_d = 1'b1;
                    OP_PEDAL_UP: begin
                        pedal_d = 1'b0;
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (sus_q[i]) begin
                                gate_d[i] = 1'b0;
                                sus_d[i]  = 1'b0;
                            end
                        end
                    end
                    OP_ALL_OFF: begin
                        gate_d = '0;
                        sus_d  = '0;
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and voice registers; reset restores ages to identity order
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            key_q   <= '0;
            val_q   <= '0;
            op_q    <= OP_NONE;
            sel_q   <= '0;
            note_q  <= '0;
            vel_q   <= '0;
            gate_q  <= '0;
            sus_q   <= '0;
            trig_q  <= '0;
            pedal_q <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= AGE_W'(i);
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            key_q   <= key_d;
            val_q   <= val_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            note_q  <= note_d;
            vel_q   <= vel_d;
            gate_q  <= gate_d;
            sus_q   <= sus_d;
            age_q   <= age_d;
            trig_q  <= trig_d;
            pedal_q <= pedal_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_midi_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_midi_voice_allocator
//  Description : Scoreboard bench for midi_voice_allocator (4 voices,
//                channel 0, omni off) driven by directed MIDI events.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_midi_voice_allocator;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic [27:0] voice_note, voice_velocity;
    logic [3:0]  voice_gate, voice_trigger;

    always #5 clk = ~clk;

    midi_voice_allocator_if evt_if ();

    midi_voice_allocator #(
        .NUM_VOICES   (4),
        .MIDI_CHANNEL (4'd0),
        .OMNI         (1'b0)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .evt            (evt_if.slave),
        .voice_note     (voice_note),
        .voice_velocity (voice_velocity),
        .voice_gate     (voice_gate),
        .voice_trigger  (voice_trigger)
    );

    typedef struct {
        logic [3:0]  gate;
        logic [27:0] note;
        logic [27:0] vel;
        logic [3:0]  trig;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   abort_mode = 1'b0;

    function automatic logic [27:0] pk(input int n0, input int n1, input int n2, input int n3);
        return {7'(n3), 7'(n2), 7'(n1), 7'(n0)};
    endfunction

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ack starts a transaction; outputs are compared two
    // edges after capture, and the trigger must clear one cycle later
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (evt_if.midi_event_ack && !abort_mode) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 28'd1, 28'd0);
                end else begin
                    e = exp_q.pop_front();
                    @(negedge clk);
                    check("ack_one_cycle", {27'd0, evt_if.midi_event_ack}, 28'd0);
                    @(negedge clk);
                    check("gate",     voice_gate,     e.gate);
                    check("note",     voice_note,     e.note);
                    check("velocity", voice_velocity, e.vel);
                    check("trigger",  voice_trigger,  e.trig);
                    @(negedge clk);
                    check("trigger_clear", voice_trigger, 28'd0);
                end
            end
        end
    end

    task automatic wait_ack(output bit got);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (evt_if.midi_event_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ack_timeout", 28'd0, 28'd1);
    endtask

    task automatic send(input logic [7:0] cmd, input int p1, input int p2,
                        input logic [3:0] g, input logic [27:0] n,
                        input logic [27:0] v, input logic [3:0] t);
        exp_t e;
        bit   got;
        @(posedge clk);
        #1;
        evt_if.midi_command     = cmd;
        evt_if.midi_parameter_1 = 7'(p1);
        evt_if.midi_parameter_2 = 7'(p2);
        evt_if.midi_event_valid = 1'b1;
        wait_ack(got);
        if (got) begin
            e.gate = g; e.note = n; e.vel = v; e.trig = t;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        evt_if.midi_event_valid = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        bit got;
        evt_if.midi_command     = 8'h00;
        evt_if.midi_parameter_1 = 7'd0;
        evt_if.midi_parameter_2 = 7'd0;
        evt_if.midi_event_valid = 1'b0;
        #12;
        check("reset_ack",      {27'd0, evt_if.midi_event_ack}, 28'd0);
        check("reset_gate",     voice_gate,     28'd0);
        check("reset_note",     voice_note,     28'd0);
        check("reset_velocity", voice_velocity, 28'd0);
        check("reset_trigger",  voice_trigger,  28'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Fill all four voices, then steal the oldest and retrigger a held one
        send(8'h90, 60, 100, 4'b0001, pk(60,0,0,0),    pk(100,0,0,0),    4'b0001);
        send(8'h90, 62,  90, 4'b0011, pk(60,62,0,0),   pk(100,90,0,0),   4'b0010);
        send(8'h90, 64,  80, 4'b0111, pk(60,62,64,0),  pk(100,90,80,0),  4'b0100);
        send(8'h90, 65,  70, 4'b1111, pk(60,62,64,65), pk(100,90,80,70), 4'b1000);
        send(8'h90, 67,  50, 4'b1111, pk(67,62,64,65), pk(50,90,80,70),  4'b0001);
        send(8'h90, 62, 110, 4'b1111, pk(67,62,64,65), pk(50,110,80,70), 4'b0010);
        // Note-offs, velocity-0 off, unmatched key, wrong channel, ignored command
        send(8'h80, 64,   0, 4'b1011, pk(67,62,64,65), pk(50,110,80,70), 4'b0000);
        send(8'h90, 67,   0, 4'b1010, pk(67,62,64,65), pk(50,110,80,70), 4'b0000);
        send(8'h80, 61,   0, 4'b1010, pk(67,62,64,65), pk(50,110,80,70), 4'b0000);
        send(8'h91, 70, 100, 4'b1010, pk(67,62,64,65), pk(50,110,80,70), 4'b0000);
        send(8'hA0, 62,  30, 4'b1010, pk(67,62,64,65), pk(50,110,80,70), 4'b0000);
        send(8'hB0, 123,  0, 4'b0000, pk(67,62,64,65), pk(50,110,80,70), 4'b0000);
        // Sustain pedal behaviour
        send(8'hB0, 64, 127, 4'b0000, pk(67,62,64,65), pk(50,110,80,70), 4'b0000);
        send(8'h90, 60, 100, 4'b0001, pk(60,62,64,65), pk(100,110,80,70), 4'b0001);
        send(8'h80, 60,   0, 4'b0001, pk(60,62,64,65), pk(100,110,80,70), 4'b0000);
        send(8'hB0, 64, 127, 4'b0001, pk(60,62,64,65), pk(100,110,80,70), 4'b0000);
        send(8'h90, 60,   0, 4'b0001, pk(60,62,64,65), pk(100,110,80,70), 4'b0000);
        send(8'hB0, 64,   0, 4'b0000, pk(60,62,64,65), pk(100,110,80,70), 4'b0000);
        send(8'hB0, 64,  10, 4'b0000, pk(60,62,64,65), pk(100,110,80,70), 4'b0000);
        // Off-channel all-notes-off must not touch a held voice
        send(8'h90, 72, 100, 4'b0001, pk(72,62,64,65), pk(100,110,80,70), 4'b0001);
        send(8'hB1, 123,  0, 4'b0001, pk(72,62,64,65), pk(100,110,80,70), 4'b0000);
        send(8'h80, 72,   0, 4'b0000, pk(72,62,64,65), pk(100,110,80,70), 4'b0000);

        // Reset during DECODE; framer keeps valid so the event is recaptured
        repeat (3) @(posedge clk);
        abort_mode = 1'b1;
        @(posedge clk);
        #1;
        evt_if.midi_command     = 8'h90;
        evt_if.midi_parameter_1 = 7'd48;
        evt_if.midi_parameter_2 = 7'd100;
        evt_if.midi_event_valid = 1'b1;
        wait_ack(got);
        resetn = 1'b0;
        #1;
        check("abort_ack",      {27'd0, evt_if.midi_event_ack}, 28'd0);
        check("abort_gate",     voice_gate,     28'd0);
        check("abort_note",     voice_note,     28'd0);
        check("abort_velocity", voice_velocity, 28'd0);
        check("abort_trigger",  voice_trigger,  28'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn     = 1'b1;
        abort_mode = 1'b0;
        wait_ack(got);
        if (got) begin
            exp_t e;
            e.gate = 4'b0001; e.note = pk(48,0,0,0); e.vel = pk(100,0,0,0); e.trig = 4'b0001;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        evt_if.midi_event_valid = 1'b0;

        repeat (8) @(posedge clk);
        check("scoreboard_drained", 28'(exp_q.size()), 28'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
